// File: rtl/imm_ext_pkg.sv
// Shared encodings for the pipelined immediate extender: extension modes and
// skid-buffer FSM states.
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;
    typedef logic [1:0] imm_state_t;

    localparam imm_mode_t IMM_MODE_SIGN   = 2'b00;
    localparam imm_mode_t IMM_MODE_ZERO   = 2'b01;
    localparam imm_mode_t IMM_MODE_UPPER  = 2'b10;
    localparam imm_mode_t IMM_MODE_BRANCH = 2'b11;

    localparam imm_state_t ST_EMPTY = 2'b00;
    localparam imm_state_t ST_ONE   = 2'b01;
    localparam imm_state_t ST_FULL  = 2'b10;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational IN_W->OUT_W immediate extension: sign, zero, upper (shift into
// the high bits) and branch offset (sign-extend, then word-align by <<2).
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  data_i,
    input  imm_mode_t        mode_i,
    output logic [OUT_W-1:0] ext_o
);

    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD{data_i[IN_W-1]}}, data_i};

    always_comb begin
        ext_o = '0;
        case (mode_i)
            IMM_MODE_SIGN:   ext_o = sext;
            IMM_MODE_ZERO:   ext_o = {{PAD{1'b0}}, data_i};
            IMM_MODE_UPPER:  ext_o = {data_i, {PAD{1'b0}}};
            IMM_MODE_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
            default:         ext_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer behind valid/ready.
// Optional transfer counter (xfer_cnt_o) enabled by defining IMM_EXT_STATS_EN.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  imm_mode_t        mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt_o
`endif
);

    if (IN_W < 2 || IN_W > OUT_W - 2 || CNT_W < 1) begin : g_bad_params
        $error("imm_extend_pipe: illegal IN_W/OUT_W/CNT_W combination");
    end

    imm_state_t       state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [OUT_W-1:0] ext;
    logic             in_fire, out_fire;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data_i (data_i),
        .mode_i (mode_i),
        .ext_o  (ext)
    );

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = (state_q != ST_FULL);
    assign data_o      = main_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    // main always holds the oldest word; skid only fills when main is stalled
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = ext;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = ST_FULL;
                    skid_d  = ext;
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire && out_fire) begin
                    main_d  = ext;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_fire && (xfer_cnt_q != {CNT_W{1'b1}})) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized checks for imm_extend_pipe (IN_W=16, OUT_W=32, CNT_W=4).
module tb_imm_extend_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] data_i = '0;
    logic [1:0]  mode_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] data_o;
`ifdef IMM_EXT_STATS_EN
    logic [3:0]  xfer_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .CNT_W (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o)
`ifdef IMM_EXT_STATS_EN
        ,
        .xfer_cnt_o  (xfer_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{d[15]}}, d};
        case (m)
            2'b00:   return s;
            2'b01:   return {16'h0000, d};
            2'b10:   return {d, 16'h0000};
            default: return s << 2;
        endcase
    endfunction

    // Scoreboard: sampled on the falling edge, when handshake signals are settled
    logic [31:0] q[$];
    bit          mon_en = 1'b0;
    int          push_cnt = 0;
    int          pop_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk_i) begin
        if (mon_en && rst_i) begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
                chk("stall_data", data_o, prev_data);
            end
            prev_stall = out_valid_o & ~out_ready_i;
            prev_data  = data_o;
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    chk("dup_output", data_o, 32'hxxxx_xxxx);
                end else begin
                    chk("sb_data", data_o, q.pop_front());
                end
                pop_cnt++;
            end
            if (in_valid_i && in_ready_o) begin
                q.push_back(ref_ext(data_i, mode_i));
                push_cnt++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    logic [15:0] mode_data;
    logic [31:0] mode_exp [4];
    int          base_push, base_pop;
    bit          stream_stall;

    initial begin
        mode_data   = 16'h8001;
        mode_exp[0] = 32'hFFFF8001;
        mode_exp[1] = 32'h00008001;
        mode_exp[2] = 32'h80010000;
        mode_exp[3] = 32'hFFFE0004;

        // reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_data", data_o, 32'd0);
`ifdef IMM_EXT_STATS_EN
        chk("rst_cnt", {28'd0, xfer_cnt_o}, 32'd0);
`endif
        cyc();
        cyc();
        rst_i = 1'b1;

        // each mode on 16'h8001, one cycle latency
        out_ready_i = 1'b1;
        for (int m = 0; m < 4; m++) begin
            cyc();
            in_valid_i = 1'b1;
            data_i     = mode_data;
            mode_i     = m[1:0];
            cyc();
            in_valid_i = 1'b0;
            chk($sformatf("mode%0d_valid", m), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("mode%0d_data", m), data_o, mode_exp[m]);
        end
        cyc();
        chk("mode_drained", {31'd0, out_valid_o}, 32'd0);

        // back-pressure fills the skid buffer
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        data_i      = 16'h0001;
        mode_i      = 2'b01;
        cyc();
        data_i = 16'h0002;
        cyc();
        in_valid_i = 1'b0;
        chk("bp_full_ready", {31'd0, in_ready_o}, 32'd0);
        chk("bp_full_valid", {31'd0, out_valid_o}, 32'd1);
        chk("bp_hold_a", data_o, 32'h1);
        cyc();
        chk("bp_hold_a2", data_o, 32'h1);
        out_ready_i = 1'b1;
        cyc();
        chk("bp_second_b", data_o, 32'h2);
        chk("bp_ready_back", {31'd0, in_ready_o}, 32'd1);
        chk("bp_b_valid", {31'd0, out_valid_o}, 32'd1);
        cyc();
        chk("bp_empty", {31'd0, out_valid_o}, 32'd0);

        // streaming at full rate
        mon_en       = 1'b1;
        base_pop     = pop_cnt;
        stream_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (!in_ready_o) stream_stall = 1'b1;
            in_valid_i = 1'b1;
            data_i     = 16'($urandom);
            mode_i     = 2'($urandom_range(0, 3));
        end
        cyc();
        in_valid_i = 1'b0;
        cyc();
        chk("stream_count", pop_cnt - base_pop, 32'd100);
        chk("stream_no_stall", {31'd0, stream_stall}, 32'd0);
        chk("stream_empty", {31'd0, out_valid_o}, 32'd0);

        // random valid/ready toggling
        base_push = push_cnt;
        base_pop  = pop_cnt;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            in_valid_i  = 1'($urandom_range(0, 1));
            out_ready_i = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (i >= 5000) out_ready_i = 1'($urandom_range(0, 1));
            data_i      = 16'($urandom);
            mode_i      = 2'($urandom_range(0, 3));
        end
        cyc();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid_o); i++) cyc();
        cyc();
        chk("rand_q_empty", q.size(), 32'd0);
        chk("rand_balance", push_cnt - base_push, pop_cnt - base_pop);
        chk("rand_idle", {31'd0, out_valid_o}, 32'd0);

        // asynchronous reset while FULL
        mon_en      = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        data_i      = 16'hAAAA;
        mode_i      = 2'b00;
        cyc();
        data_i = 16'h5555;
        cyc();
        in_valid_i = 1'b0;
        chk("pre_rst_full", {31'd0, in_ready_o}, 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready_o}, 32'd1);
        chk("mid_rst_data", data_o, 32'd0);
`ifdef IMM_EXT_STATS_EN
        chk("mid_rst_cnt", {28'd0, xfer_cnt_o}, 32'd0);
`endif
        q.delete();
        cyc();
        #2;
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        cyc();
        chk("post_rst_idle", {31'd0, out_valid_o}, 32'd0);
        in_valid_i = 1'b1;
        data_i     = 16'h1234;
        mode_i     = 2'b10;
        cyc();
        in_valid_i = 1'b0;
        chk("post_rst_data", data_o, 32'h12340000);
        cyc();
        chk("post_rst_no_stale", {31'd0, out_valid_o}, 32'd0);
`ifdef IMM_EXT_STATS_EN
        chk("cnt_one", {28'd0, xfer_cnt_o}, 32'd1);
        in_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        in_valid_i = 1'b0;
        cyc();
        cyc();
        chk("cnt_saturated", {28'd0, xfer_cnt_o}, 32'hF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
